// File: rtl/pkt_chk_pkg.sv
// Shared constants, state encoding and byte helpers for the NET_SEND sink checker.
package pkt_chk_pkg;

    typedef enum logic {
        S_HDR  = 1'b0,
        S_BODY = 1'b1
    } state_e;

    localparam int unsigned DATA_W       = 512;
    localparam int unsigned BEAT_BYTES   = 64;
    localparam int unsigned BEAT_SHIFT   = 6;
    localparam int unsigned IDX_W        = 11;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam int unsigned ETH_HDR_BYTES  = 14;
    localparam int unsigned MIN_IP_LEN     = 28;

    localparam int unsigned OFF_ETHERTYPE  = 12;
    localparam int unsigned OFF_VER_IHL    = 14;
    localparam int unsigned OFF_IP_LEN     = 16;
    localparam int unsigned OFF_PROTO      = 23;

    localparam logic [15:0] LFSR_SEED      = 16'hACE1;

    // Byte n of a beat sits at bits [8n+7:8n] (byte 0 is first on the wire).
    function automatic logic [7:0] get_byte(input logic [DATA_W-1:0] d, input int unsigned idx);
        return d[8*idx +: 8];
    endfunction

endpackage

// File: rtl/axis_stall_gen.sv
// Pseudo-random backpressure: 16-bit Fibonacci LFSR (taps 16,14,13,11) compared against a ratio.
module axis_stall_gen
    import pkt_chk_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ratio,
    output logic       ready_c
);

    logic [15:0] lfsr;
    logic        feedback;

    assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], feedback};
        end
    end

    // Ratio 0 never stalls; larger ratios stall more often.
    assign ready_c = (lfsr[3:0] >= ratio);

endmodule

// File: rtl/axis_pkt_sink_checker.sv
// AXI-Stream sink for NET_SEND frames: header parse, length and body-pattern checks, run counters.
// Optional pseudo-random backpressure when BACKPRESSURE_EN is defined.
module axis_pkt_sink_checker
    import pkt_chk_pkg::*;
#(
    parameter int unsigned AXIS_DATA_WIDTH = 512,
    parameter int unsigned AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int unsigned CNT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    input  logic [3:0]                 cfg_stall_ratio,
    output logic                       pkt_done,
    output logic                       pkt_ok,
    output logic [15:0]                last_ip_len,
    output logic [CNT_WIDTH-1:0]       pkt_count,
    output logic [CNT_WIDTH-1:0]       beat_count,
    output logic [CNT_WIDTH-1:0]       err_hdr_count,
    output logic [CNT_WIDTH-1:0]       err_len_count,
    output logic [CNT_WIDTH-1:0]       err_pay_count
);

    state_e           state;
    logic             run_q;
    logic             stall_ready_c;
    logic             accept;
    logic [15:0]      ip_len_q;
    logic [IDX_W-1:0] exp_beats_q;
    logic [IDX_W-1:0] beat_idx;
    logic             hdr_err_q;
    logic             pay_err_q;

`ifdef BACKPRESSURE_EN
    axis_stall_gen u_stall_gen (
        .clk     (clk),
        .rst     (rst),
        .ratio   (cfg_stall_ratio),
        .ready_c (stall_ready_c)
    );
`else
    logic [3:0] unused_stall_ratio;
    assign unused_stall_ratio = cfg_stall_ratio;
    assign stall_ready_c      = 1'b1;
`endif

    assign s_axis_tready = run_q & stall_ready_c;
    assign accept        = s_axis_tvalid & s_axis_tready;

    // Header-beat decode.
    logic [15:0]      hdr_ethertype;
    logic [15:0]      hdr_ip_len;
    logic [16:0]      hdr_exp_sum;
    logic [IDX_W-1:0] hdr_exp_beats;
    logic             hdr_bad;

    assign hdr_ethertype = {get_byte(s_axis_tdata, OFF_ETHERTYPE), get_byte(s_axis_tdata, OFF_ETHERTYPE + 1)};
    assign hdr_ip_len    = {get_byte(s_axis_tdata, OFF_IP_LEN), get_byte(s_axis_tdata, OFF_IP_LEN + 1)};
    assign hdr_exp_sum   = 17'(hdr_ip_len) + 17'(ETH_HDR_BYTES) + 17'(BEAT_BYTES - 1);
    assign hdr_exp_beats = IDX_W'(hdr_exp_sum >> BEAT_SHIFT);
    assign hdr_bad       = (hdr_ethertype != ETHERTYPE_IPV4)
                         | (get_byte(s_axis_tdata, OFF_VER_IHL) != IPV4_VER_IHL)
                         | (get_byte(s_axis_tdata, OFF_PROTO) != IP_PROTO_UDP)
                         | (hdr_ip_len < 16'(MIN_IP_LEN))
                         | ~(&s_axis_tkeep);

    // Body beat k must carry k in its low 64 bits and zeros above; non-last beats must be full.
    logic body_bad;

    assign body_bad = (s_axis_tdata[63:0] != 64'(beat_idx))
                    | (|s_axis_tdata[AXIS_DATA_WIDTH-1:64])
                    | (~s_axis_tlast & ~(&s_axis_tkeep));

    // Frame verdict as seen on the tlast beat.
    logic        fin_hdr_err;
    logic        fin_len_err;
    logic        fin_pay_err;
    logic [15:0] fin_ip_len;

    always_comb begin
        fin_hdr_err = hdr_bad;
        fin_len_err = (hdr_exp_beats != IDX_W'(1));
        fin_pay_err = 1'b0;
        fin_ip_len  = hdr_ip_len;
        if (state == S_BODY) begin
            fin_hdr_err = hdr_err_q;
            fin_len_err = ((12'(beat_idx) + 12'd1) != 12'(exp_beats_q));
            fin_pay_err = pay_err_q | body_bad;
            fin_ip_len  = ip_len_q;
        end
    end

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_HDR;
            run_q         <= 1'b0;
            ip_len_q      <= '0;
            exp_beats_q   <= '0;
            beat_idx      <= '0;
            hdr_err_q     <= 1'b0;
            pay_err_q     <= 1'b0;
            pkt_done      <= 1'b0;
            pkt_ok        <= 1'b0;
            last_ip_len   <= '0;
            pkt_count     <= '0;
            beat_count    <= '0;
            err_hdr_count <= '0;
            err_len_count <= '0;
            err_pay_count <= '0;
        end else begin
            run_q    <= 1'b1;
            pkt_done <= 1'b0;
            if (accept) begin
                beat_count <= sat_inc(beat_count);
                case (state)
                    S_HDR: begin
                        ip_len_q    <= hdr_ip_len;
                        exp_beats_q <= hdr_exp_beats;
                        hdr_err_q   <= hdr_bad;
                        pay_err_q   <= 1'b0;
                        beat_idx    <= IDX_W'(1);
                        if (!s_axis_tlast) begin
                            state <= S_BODY;
                        end
                    end
                    S_BODY: begin
                        pay_err_q <= pay_err_q | body_bad;
                        if (beat_idx != '1) begin
                            beat_idx <= beat_idx + IDX_W'(1);
                        end
                        if (s_axis_tlast) begin
                            state <= S_HDR;
                        end
                    end
                    default: state <= S_HDR;
                endcase
                if (s_axis_tlast) begin
                    pkt_done    <= 1'b1;
                    pkt_ok      <= ~(fin_hdr_err | fin_len_err | fin_pay_err);
                    last_ip_len <= fin_ip_len;
                    pkt_count   <= sat_inc(pkt_count);
                    if (fin_hdr_err) err_hdr_count <= sat_inc(err_hdr_count);
                    if (fin_len_err) err_len_count <= sat_inc(err_len_count);
                    if (fin_pay_err) err_pay_count <= sat_inc(err_pay_count);
                end
            end
        end
    end

endmodule

// File: doc/axis_pkt_sink_checker.md
Name: axis_pkt_sink_checker

Overview:
- AXI-Stream sink for the ep2top network transmit output (NET_SEND side).
- Accepts 512-bit beats carrying Ethernet/IPv4/UDP frames.
- Parses the header beat, checks the frame length against the beats actually received, and checks the body-beat sequence pattern (beat k carries k).
- Keeps per-run counters and per-packet status pulses for simulation and on-board bring-up.

Parameters:
- AXIS_DATA_WIDTH, 512, stream data width; must be 512.
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width.
- CNT_WIDTH, 32, width of all statistic counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- s_axis_tdata  in  512  frame data; byte 0 = bits [7:0] = first byte on the wire.
- s_axis_tkeep  in  64  byte enables.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  sink ready.
- s_axis_tlast  in  1  last beat of frame.
- cfg_stall_ratio  in  4  backpressure strength; used only with BACKPRESSURE_EN.
- pkt_done  out  1  one-cycle pulse per completed frame.
- pkt_ok  out  1  valid with pkt_done; 1 = no error in that frame.
- last_ip_len  out  16  IPv4 total length of the most recent frame.
- pkt_count  out  CNT_WIDTH  frames completed.
- beat_count  out  CNT_WIDTH  beats accepted.
- err_hdr_count  out  CNT_WIDTH  frames with a header error.
- err_len_count  out  CNT_WIDTH  frames with a length mismatch.
- err_pay_count  out  CNT_WIDTH  frames with a payload-pattern error.

Behaviour:
- Reset (rst==0 at a clk edge):
  - All counters, pkt_done, pkt_ok and last_ip_len go to 0.
  - State goes to S_HDR; tready = 0.
  - tready rises on the first cycle after rst deasserts.
  - Reset mid-frame discards the partial frame; the next accepted beat is treated as a header.
- Beat acceptance: a beat is accepted when tvalid && tready. beat_count increments by 1 per accepted beat.
- States:
  - S_HDR → S_BODY on an accepted beat with tlast=0.
  - S_HDR stays in S_HDR on an accepted beat with tlast=1 (single-beat frame).
  - S_BODY → S_HDR on an accepted beat with tlast=1; otherwise stays.
- Header checks (S_HDR beat); hdr_err is set if any of these fails:
  - byte12=0x08 and byte13=0x00 (IPv4 ethertype).
  - byte14=0x45.
  - byte23=0x11 (UDP).
  - ip_len={byte16,byte17} >= 28.
  - tkeep all ones.
- Header-beat latching: ip_len is latched. exp_beats = (ip_len + 14 + 63) >> 6, computed at 17-bit width and truncated to 11 bits.
- Beat index: counter starts at 1 on the first body beat and saturates at 2047.
- Payload check (S_BODY beat k): tdata[63:0]==k and tdata[511:64]==0; otherwise pay_err.
- Keep check: non-last body beats must have tkeep all ones; otherwise pay_err.
- Length check at tlast: len_err if total beats != exp_beats. Total beats is 1 for a header-only frame.
- Error flags are sticky within a frame. Each error counter increments at most once per frame.
- Frame completion (cycle after the tlast beat is accepted):
  - pkt_done=1 and pkt_ok=!(hdr_err|len_err|pay_err) for exactly one cycle.
  - pkt_count, the error counters and last_ip_len update in that same cycle.
- Back-to-back frames: a new header may be accepted in the same cycle as pkt_done; no bubble is required.
- All counters saturate at all-ones.
- Latency: status appears 1 cycle after the tlast beat.

Optional Feature:
- Macro: BACKPRESSURE_EN.
- Defined:
  - An axis_stall_gen instance runs a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset), advancing every cycle.
  - tready = (lfsr[3:0] >= cfg_stall_ratio). Ratio 0 means never stall.
  - tready may drop while tvalid is high; the sender must hold its beat.
- Undefined: tready = 1 whenever out of reset; cfg_stall_ratio is ignored.

Decomposition:
- Package pkt_chk_pkg:
  - State enum {S_HDR, S_BODY}.
  - ETHERTYPE_IPV4=16'h0800, IPV4_VER_IHL=8'h45, IP_PROTO_UDP=8'h11.
  - ETH_HDR_BYTES=14, MIN_IP_LEN=28.
  - Byte offsets 12, 14, 16, 23.
  - BEAT_BYTES=64.
- Sub-module: axis_stall_gen (LFSR plus compare), instantiated only under BACKPRESSURE_EN.

Test Plan:
- Single-beat frame, ip_len=50, valid header → pkt_done one cycle after the beat; pkt_ok=1, pkt_count=1, beat_count=1, last_ip_len=50.
- 4-beat frame, ip_len=242, body beats carry 1,2,3, sent back-to-back 16 times → pkt_count=16, beat_count=64, all error counters 0.
- 4-beat frame with ip_len=178 (expects 3 beats) → pkt_ok=0, err_len_count=1, other error counters 0.
- 3-beat frame, second body beat carries 7 instead of 2 → err_pay_count=1; next good frame gives pkt_ok=1.
- Header byte23=0x06, 2-beat frame → err_hdr_count=1; reset asserted mid-frame of a following 4-beat frame → all counters 0, and the subsequent frame is parsed from its header.
- With BACKPRESSURE_EN and cfg_stall_ratio=8, 100 frames of 2 beats → tready toggles; pkt_count=100, beat_count=200, no errors, no beat lost or duplicated.
